// File: rtl/pwm_pkg.sv
// Purpose : shared types for the multi-channel PWM engine.
// Latency : none (types and constants only).
// Backpressure: none.
package pwm_pkg;

    // Counter shape of a channel; the encoding matches the PWM_MODE register bit.
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Supported parameter ranges.
    localparam int PWM_MAX_CH    = 16;
    localparam int PWM_MIN_CNT_W = 2;
    localparam int PWM_MAX_CNT_W = 32;

endpackage

// File: rtl/pwm_multi_core_if.sv
// Purpose : config/status bundle between the PWM register slave (master) and the PWM core (slave).
// Latency : wires only.
// Backpressure: none; config is sampled every cycle, status is a registered snapshot.
// Signals : PWM_DIV prescaler divide; PWM_EN/INV/MODE/UPD per-channel control bits;
//           PWM_PERIOD/PWM_DUTY packed per channel (ch i at [i*P_CNT_W +: P_CNT_W]);
//           PWM_PEND/PWM_CYC_END/PWM_OUT per-channel status and pad outputs.
interface pwm_multi_core_if #(
    parameter int P_NUM_CH = 4,
    parameter int P_CNT_W  = 16,
    parameter int P_DIV_W  = 8
);
    logic [P_DIV_W-1:0]          PWM_DIV;
    logic [P_NUM_CH-1:0]         PWM_EN;
    logic [P_NUM_CH-1:0]         PWM_INV;
    logic [P_NUM_CH-1:0]         PWM_MODE;
    logic [P_NUM_CH*P_CNT_W-1:0] PWM_PERIOD;
    logic [P_NUM_CH*P_CNT_W-1:0] PWM_DUTY;
    logic [P_NUM_CH-1:0]         PWM_UPD;
    logic [P_NUM_CH-1:0]         PWM_PEND;
    logic [P_NUM_CH-1:0]         PWM_CYC_END;
    logic [P_NUM_CH-1:0]         PWM_OUT;

    modport master (
        output PWM_DIV, PWM_EN, PWM_INV, PWM_MODE, PWM_PERIOD, PWM_DUTY, PWM_UPD,
        input  PWM_PEND, PWM_CYC_END, PWM_OUT
    );

    modport slave (
        input  PWM_DIV, PWM_EN, PWM_INV, PWM_MODE, PWM_PERIOD, PWM_DUTY, PWM_UPD,
        output PWM_PEND, PWM_CYC_END, PWM_OUT
    );
endinterface

// File: rtl/pwm_ch.sv
// Purpose : one PWM channel: shadow/active config, up or up/down counter, compare, output flop.
// Latency : out and cyc_end are registered, one CLK after the counter value they reflect.
// Backpressure: none; upd is always accepted (a pending shadow is simply overwritten).
// Ports   : CLK, RST (sync, active-high); tick = shared prescaler strobe; en = live run enable;
//           upd = capture cfg {period, duty, mode, inv} into shadow; pend = shadow not yet
//           committed; cyc_end = one-cycle pulse after a period boundary; out = PWM pad.
module pwm_ch
    import pwm_pkg::*;
#(
    parameter int P_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 upd,
    input  logic [2*P_CNT_W+1:0] cfg,
    output logic                 pend,
    output logic                 cyc_end,
    output logic                 out
);

    typedef struct packed {
        logic [P_CNT_W-1:0] period;
        logic [P_CNT_W-1:0] duty;
        pwm_mode_e          mode;
        logic               inv;
    } pwm_ch_cfg_t;

    localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);

    pwm_ch_cfg_t        cfg_in;
    pwm_ch_cfg_t        shadow_q, shadow_d;
    pwm_ch_cfg_t        active_q, active_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;       // direction of the next step: 0 = up, 1 = down
    logic               pend_q, pend_d;
    logic               cyc_end_q, cyc_end_d;
    logic               out_q, out_d;
    logic               boundary;
    logic               commit;
    logic               raw;

    assign cfg_in = pwm_ch_cfg_t'(cfg);

    always_comb begin
        boundary  = 1'b0;
        commit    = 1'b0;
        raw       = 1'b0;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pend_d    = pend_q;
        cyc_end_d = 1'b0;
        out_d     = out_q;

        // Last tick of the current cycle. In center mode dir already reads "down"
        // while sitting on the peak, so the 1 -> 0 step is the only down step at cnt==1.
        if (active_q.mode == PWM_EDGE) begin
            boundary = en & tick & (cnt_q == active_q.period);
        end else begin
            boundary = en & tick & ((active_q.period == '0) | (dir_q & (cnt_q == CNT_ONE)));
        end

        // A stopped channel has no boundaries, so a pending update goes straight in.
        commit = pend_q & (boundary | ~en);

        if (!en) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (tick) begin
            if (active_q.mode == PWM_EDGE) begin
                cnt_d = (cnt_q == active_q.period) ? '0 : cnt_q + CNT_ONE;
            end else if (active_q.period == '0) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end else if (!dir_q) begin
                cnt_d = cnt_q + CNT_ONE;
                dir_d = ((cnt_q + CNT_ONE) == active_q.period);
            end else begin
                cnt_d = cnt_q - CNT_ONE;
                dir_d = (cnt_q != CNT_ONE);
            end
        end

        if (commit) begin
            active_d = shadow_q;
            cnt_d    = '0;
            dir_d    = 1'b0;
        end

        // An update in the commit cycle lands in the shadow after the old shadow moved out,
        // so the channel stays pending for the next boundary.
        if (upd) begin
            shadow_d = cfg_in;
        end
        pend_d = upd | (pend_q & ~commit);

        // duty > period never compares false, giving a constant-high output.
        raw       = (cnt_q < active_q.duty);
        out_d     = en ? (raw ^ active_q.inv) : active_q.inv;
        cyc_end_d = boundary;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q  <= '0;
            active_q  <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            pend_q    <= 1'b0;
            cyc_end_q <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            cyc_end_q <= cyc_end_d;
            out_q     <= out_d;
        end
    end

    assign pend    = pend_q;
    assign cyc_end = cyc_end_q;
    assign out     = out_q;

endmodule

// File: rtl/pwm_multi_core.sv
// Purpose : N-channel PWM engine: one shared prescaler feeding P_NUM_CH pwm_ch instances.
// Latency : pad outputs are registered, one CLK behind the channel counters.
// Backpressure: none; config from the register slave is accepted every cycle.
// Ports   : CLK, RST (sync, active-high); bus = slave side of pwm_multi_core_if
//           (config in, PWM_PEND / PWM_CYC_END / PWM_OUT out).
module pwm_multi_core
    import pwm_pkg::*;
#(
    parameter int P_NUM_CH = 4,
    parameter int P_CNT_W  = 16,
    parameter int P_DIV_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    pwm_multi_core_if.slave  bus
);

    logic [P_DIV_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic                tick;
    logic [P_NUM_CH-1:0] pend_v;
    logic [P_NUM_CH-1:0] cyc_end_v;
    logic [P_NUM_CH-1:0] out_v;

    // Lowering PWM_DIV below the running count is not corrected: the count runs on,
    // wraps through zero and only then matches again.
    always_comb begin
        tick      = (pre_cnt_q == bus.PWM_DIV);
        pre_cnt_d = tick ? '0 : pre_cnt_q + P_DIV_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar i = 0; i < P_NUM_CH; i++) begin : g_ch
        pwm_mode_e            mode;
        logic [2*P_CNT_W+1:0] cfg;

        assign mode = pwm_mode_e'(bus.PWM_MODE[i]);
        assign cfg  = {bus.PWM_PERIOD[i*P_CNT_W +: P_CNT_W],
                       bus.PWM_DUTY[i*P_CNT_W +: P_CNT_W],
                       mode,
                       bus.PWM_INV[i]};

        pwm_ch #(
            .P_CNT_W (P_CNT_W)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .tick    (tick),
            .en      (bus.PWM_EN[i]),
            .upd     (bus.PWM_UPD[i]),
            .cfg     (cfg),
            .pend    (pend_v[i]),
            .cyc_end (cyc_end_v[i]),
            .out     (out_v[i])
        );
    end

    assign bus.PWM_PEND    = pend_v;
    assign bus.PWM_CYC_END = cyc_end_v;
    assign bus.PWM_OUT     = out_v;

endmodule
